// File: rtl/spi_command_sequencer.sv
// spi_command_sequencer: decodes SPI commands, stages whole records and drains them into the segment fifo.
// Optional per-record XOR checksum byte enabled by defining SEQ_CHECKSUM_EN.
module spi_command_sequencer #(
    parameter int WordSize = 8,
    parameter int RecordWords = 16,
    parameter int Depth = 16,
    parameter logic [7:0] CmdStatus = 8'h01,
    parameter logic [7:0] CmdWriteFifo = 8'h02
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   spi_cs,
    input  logic [WordSize-1:0]                    rx_word,
    input  logic                                   rx_valid,
    output logic [WordSize-1:0]                    tx_word,
    input  logic [$clog2(Depth*RecordWords):0]     fifo_size,
    input  logic                                   fifo_full,
    output logic                                   fifo_write_en,
    output logic [WordSize-1:0]                    fifo_data,
    output logic                                   busy,
    output logic                                   overflow,
    output logic                                   record_done
);
    localparam int LogRw = $clog2(RecordWords);
    localparam int CntW = LogRw + 1;
    localparam int SumW = $clog2(Depth*RecordWords) + 2;
`ifdef SEQ_CHECKSUM_EN
    localparam int LastCnt = RecordWords;
`else
    localparam int LastCnt = RecordWords - 1;
`endif
    typedef enum logic {IDLE, RECV} rx_state_t;
    typedef enum logic {D_IDLE, D_BUSY} drain_state_t;
    rx_state_t rx_state, rx_next;
    drain_state_t d_state, d_next;
    logic [CntW-1:0] byte_cnt;
    logic [LogRw-1:0] idx;
    logic [WordSize-1:0] staging [RecordWords];
    logic [WordSize-1:0] drain_buf [RecordWords];
    logic [WordSize-1:0] rec_words [RecordWords];
    logic [CntW-1:0] drain_remaining;
    logic [SumW-1:0] used_words;
    logic [6:0] slots_free;
    logic rx_fire, rec_complete, csum_ok, room, accept, drop_ovf, status_cmd, csum_err;
    assign rx_fire = rx_valid && !spi_cs;
    assign rec_complete = rx_fire && rx_state == RECV && byte_cnt == CntW'(LastCnt);
    assign status_cmd = rx_fire && rx_state == IDLE && rx_word == CmdStatus;
    assign drain_remaining = d_state == D_BUSY ? CntW'(RecordWords) - CntW'(idx) : '0;
    assign used_words = SumW'(fifo_size) + SumW'(drain_remaining);
    assign slots_free = 7'(Depth) - 7'(used_words >> LogRw);
    assign room = slots_free != 7'd0 && !slots_free[6];
    assign accept = rec_complete && csum_ok && room && d_state == D_IDLE;
    assign drop_ovf = rec_complete && csum_ok && !(room && d_state == D_IDLE);
    assign tx_word = rx_state == IDLE ? {overflow, csum_err, slots_free[WordSize-3:0]} : '0;
`ifdef SEQ_CHECKSUM_EN
    logic [WordSize-1:0] csum;
    always_comb begin
        csum = rx_word;
        for (int k = 0; k < RecordWords; k++) csum = csum ^ staging[k];
    end
    assign csum_ok = csum == '0;
    assign rec_words = staging;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) csum_err <= 1'b0;
        else if (status_cmd) csum_err <= 1'b0;
        else if (rec_complete && !csum_ok) csum_err <= 1'b1;
`else
    assign csum_ok = 1'b1;
    assign csum_err = 1'b0;
    // the final word arrives in the completing cycle, so it bypasses staging
    always_comb begin
        rec_words = staging;
        rec_words[RecordWords-1] = rx_word;
    end
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_state <= IDLE;
            d_state <= D_IDLE;
        end else begin
            rx_state <= rx_next;
            d_state <= d_next;
        end
    always_comb begin
        rx_next = rx_state;
        if (spi_cs) rx_next = IDLE;
        else if (rx_fire && rx_state == IDLE && rx_word == CmdWriteFifo) rx_next = RECV;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) byte_cnt <= '0;
        else if (spi_cs || (rx_fire && rx_state == IDLE)) byte_cnt <= '0;
        else if (rx_fire) byte_cnt <= rec_complete ? '0 : byte_cnt + 1'b1;
    always_ff @(posedge clk) begin
        if (rx_fire && rx_state == RECV && !byte_cnt[LogRw]) staging[byte_cnt[LogRw-1:0]] <= rx_word;
        if (accept) drain_buf <= rec_words;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) overflow <= 1'b0;
        else if (status_cmd) overflow <= 1'b0;
        else if (drop_ovf) overflow <= 1'b1;
    always_comb begin
        d_next = d_state;
        busy = 1'b0;
        fifo_write_en = 1'b0;
        fifo_data = '0;
        record_done = 1'b0;
        if (d_state == D_BUSY) begin
            busy = 1'b1;
            fifo_write_en = !fifo_full;
            fifo_data = drain_buf[idx];
            record_done = fifo_write_en && idx == LogRw'(RecordWords - 1);
            d_next = record_done ? D_IDLE : D_BUSY;
        end else if (accept) d_next = D_BUSY;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) idx <= '0;
        else if (fifo_write_en) idx <= idx + 1'b1;
endmodule

// File: tb/tb_spi_command_sequencer.sv
// tb_spi_command_sequencer: directed checks of command decode, record staging, drain timing and reset.
module tb_spi_command_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, spi_cs = 1'b1, rx_valid = 1'b0, fifo_full = 1'b0;
    logic [7:0] rx_word = 8'h00;
    logic [8:0] fifo_size = 9'd0;
    logic [7:0] tx_word, fifo_data;
    logic fifo_write_en, busy, overflow, record_done;
    int passed = 0, total = 0, cyc = 0, rx_cyc = 0, n_wr = 0, n_rd = 0;
    logic [7:0] wr_data [512];
    int wr_cyc [512];
    int rd_idx [64];

    spi_command_sequencer dut (
        .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .rx_word(rx_word), .rx_valid(rx_valid),
        .tx_word(tx_word), .fifo_size(fifo_size), .fifo_full(fifo_full),
        .fifo_write_en(fifo_write_en), .fifo_data(fifo_data), .busy(busy),
        .overflow(overflow), .record_done(record_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fifo_write_en) begin
            wr_data[n_wr] <= fifo_data;
            wr_cyc[n_wr] <= cyc;
            n_wr <= n_wr + 1;
        end
        if (record_done) begin
            rd_idx[n_rd] <= n_wr;
            n_rd <= n_rd + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_word = b;
        rx_valid = 1'b1;
        rx_cyc = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic end_txn();
        @(posedge clk); #1;
        spi_cs = 1'b1;
        @(posedge clk); #1;
        spi_cs = 1'b0;
    endtask

    task automatic send_record(input logic [7:0] first, input int gap);
        for (int i = 0; i < 16; i++) begin
            send_byte(first + 8'(i));
            repeat (gap) @(posedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        logic done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = !busy;
        end
        total++;
        if (!done) $display("FAIL %s_drain_timeout busy=%b required 0", name, busy);
        else passed++;
        @(negedge clk);
    endtask

    task automatic check_data(input string name, input int base, input logic [7:0] first, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (wr_data[base+i] !== first + 8'(i)) bad++;
        total++;
        if (bad != 0) $display("FAIL %s_data mismatched_words=%0d required 0 (word0=%h)", name, bad, wr_data[base]);
        else passed++;
    endtask

    task automatic check_tx(input string name, input logic [7:0] exp);
        @(negedge clk);
        total++;
        if (tx_word !== exp) $display("FAIL %s tx_word=%h required %h", name, tx_word, exp);
        else passed++;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) $display("FAIL %s got=%0d required %0d", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({busy, fifo_write_en, fifo_data, record_done, overflow} !== 12'h0)
            $display("FAIL reset_outputs got=%b%b%h%b%b required all 0", busy, fifo_write_en, fifo_data, record_done, overflow);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        spi_cs = 1'b0;
        send_byte(8'h01);
        check_tx("status_empty", 8'h10);
        check_int("status_no_writes", n_wr, 0);
    endtask

    task automatic test_single_record();
        int base = n_wr, rd0 = n_rd;
        send_byte(8'h02);
        send_record(8'h00, 0);
        wait_idle("single");
        check_int("single_count", n_wr - base, 16);
        check_data("single", base, 8'h00, 16);
        check_int("single_first_latency", wr_cyc[base] - rx_cyc, 1);
        check_int("single_consecutive", wr_cyc[base+15] - rx_cyc, 16);
        check_int("single_done_pulses", n_rd - rd0, 1);
        check_int("single_done_word", rd_idx[rd0] - base, 15);
        fifo_size = 9'd16;
        end_txn();
        send_byte(8'h01);
        check_tx("status_after_one", 8'h0F);
    endtask

    task automatic test_partial_discard();
        int base = n_wr;
        end_txn();
        send_byte(8'h02);
        for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
        end_txn();
        send_byte(8'h02);
        send_record(8'h30, 0);
        wait_idle("partial");
        check_int("partial_count", n_wr - base, 16);
        check_data("partial", base, 8'h30, 16);
        fifo_size = 9'd32;
    endtask

    task automatic test_overflow();
        int base = n_wr;
        fifo_size = 9'd256;
        end_txn();
        send_byte(8'h02);
        send_record(8'h70, 0);
        repeat (20) @(negedge clk);
        check_int("overflow_no_writes", n_wr - base, 0);
        check_int("overflow_flag", int'(overflow), 1);
        end_txn();
        check_tx("overflow_status", 8'h80);
        send_byte(8'h01);
        check_tx("overflow_cleared", 8'h00);
        fifo_size = 9'd0;
    endtask

    task automatic test_back_to_back();
        int base = n_wr, rd0 = n_rd;
        end_txn();
        send_byte(8'h02);
        send_record(8'h40, 6);
        send_record(8'h50, 6);
        wait_idle("b2b");
        check_int("b2b_count", n_wr - base, 32);
        check_data("b2b", base, 8'h40, 32);
        check_int("b2b_done_pulses", n_rd - rd0, 2);
        check_int("b2b_done_first", rd_idx[rd0] - base, 15);
        check_int("b2b_done_second", rd_idx[rd0+1] - base, 31);
    endtask

`ifdef SEQ_CHECKSUM_EN
    task automatic test_checksum();
        int base = n_wr;
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 16; i++) x = x ^ (8'h20 + 8'(i));
        end_txn();
        send_byte(8'h02);
        send_record(8'h20, 0);
        send_byte(x ^ 8'hFF);
        repeat (20) @(negedge clk);
        check_int("csum_bad_no_writes", n_wr - base, 0);
        end_txn();
        check_tx("csum_bad_status", 8'h50);
        send_byte(8'h02);
        send_record(8'h20, 0);
        send_byte(x);
        wait_idle("csum_good");
        check_int("csum_good_count", n_wr - base, 16);
        check_data("csum_good", base, 8'h20, 16);
        end_txn();
        send_byte(8'h01);
        check_tx("csum_cleared", 8'h10);
    endtask
`endif

    task automatic test_reset_mid_drain();
        int base = n_wr;
        logic hit = 1'b0;
        end_txn();
        send_byte(8'h02);
        send_record(8'h60, 0);
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            hit = fifo_write_en && fifo_data == 8'h65;
        end
        total++;
        if (!hit) $display("FAIL midreset_word5_seen got=0 required 1");
        else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, fifo_write_en, fifo_data, record_done, overflow} !== 12'h0)
            $display("FAIL midreset_outputs got=%b%b%h%b%b required all 0", busy, fifo_write_en, fifo_data, record_done, overflow);
        else passed++;
        total++;
        if (tx_word !== 8'h10) $display("FAIL midreset_tx tx_word=%h required 10", tx_word);
        else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_int("midreset_writes", n_wr - base, 6);
    endtask

    initial begin
        test_reset();
        test_single_record();
        test_partial_discard();
        test_overflow();
        test_back_to_back();
`ifdef SEQ_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
